// File: rtl/vid_scan_sink.sv
`timescale 1ns/1ps
// Display-side sink: raster timing generator plus a small pixel FIFO that drains
// one pixel per active clock and reports which frame the producer should render.
module vid_scan_sink #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 21,
  parameter bit HSYNC_POL  = 1'b1,
  parameter bit VSYNC_POL  = 1'b1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rstn,
  input  logic        pixel_valid_i,
  input  logic [23:0] pixel_data_i,
  output logic        pixel_ready_o,
  output logic        frame_idx_o,
  output logic [23:0] rgb_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic        underflow_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);

  logic [HW-1:0] r_hcnt, w_hcnt_nxt;
  logic [VW-1:0] r_vcnt, w_vcnt_nxt;
  logic          w_active, w_hsync, w_vsync, w_vblank_start;

  logic [23:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          w_push, w_pop;

  logic          r_ready, r_frame, r_de, r_hs, r_vs, r_uf;
  logic [23:0]   r_rgb;

  always_comb begin
    w_hcnt_nxt = r_hcnt + 1'b1;
    w_vcnt_nxt = r_vcnt;
    if (r_hcnt == H_LAST) begin
      w_hcnt_nxt = '0;
      w_vcnt_nxt = (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
    end
  end

  assign w_active       = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_hsync        = (r_hcnt >= H_SS) && (r_hcnt < H_SE);
  assign w_vsync        = (r_vcnt >= V_SS) && (r_vcnt < V_SE);
  // Frame parity flips as the raster enters vertical blanking; the reset state
  // sits on that same point but is not an entry, so it does not toggle.
  assign w_vblank_start = (w_hcnt_nxt == '0) && (w_vcnt_nxt == V_ACT);

  // Ready is registered, so a push can only land when count < depth.
  assign w_push      = pixel_valid_i && r_ready;
  assign w_pop       = w_active && (r_count != '0);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk_i) begin
    if (rstn && w_push) r_mem[r_wptr] <= pixel_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn) begin
      r_hcnt  <= '0;
      r_vcnt  <= V_ACT;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
      r_frame <= 1'b0;
      r_rgb   <= '0;
      r_de    <= 1'b0;
      r_hs    <= !HSYNC_POL;
      r_vs    <= !VSYNC_POL;
      r_uf    <= 1'b0;
    end else begin
      r_hcnt  <= w_hcnt_nxt;
      r_vcnt  <= w_vcnt_nxt;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < DEPTH);
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_vblank_start) r_frame <= ~r_frame;
      r_de  <= w_active;
      r_hs  <= HSYNC_POL ? w_hsync : !w_hsync;
      r_vs  <= VSYNC_POL ? w_vsync : !w_vsync;
      r_rgb <= w_pop ? r_mem[r_rptr] : '0;
      // Starved active pixel: show black, keep scanning, remember it until reset.
      if (w_active && (r_count == '0)) r_uf <= 1'b1;
    end
  end

  assign pixel_ready_o = r_ready;
  assign frame_idx_o   = r_frame;
  assign rgb_o         = r_rgb;
  assign hsync_o       = r_hs;
  assign vsync_o       = r_vs;
  assign de_o          = r_de;
  assign underflow_o   = r_uf;
endmodule
